control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter word_size, 8, instruction width.
REQ-002 SHALL have parameter op_size, 4, opcode width in instruction[word_size-1:word_size-op_size].
REQ-003 SHALL have parameter Sel1_size, 3, Bus_1 mux select width.
REQ-004 SHALL have parameter Sel2_size, 2, Bus_2 mux select width.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port instruction  input  word_size  IR contents {opcode, src[3:2], dest[1:0]}.
REQ-008 SHALL have port zero  input  1  registered zero flag from datapath.
REQ-009 SHALL have ports Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register load enables.
REQ-010 SHALL have ports Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, Load_PC, Inc_PC  output  1 each  datapath enables.
REQ-011 SHALL have port Sel_Bus_1_Mux  output  Sel1_size  R0=0, R1=1, R2=2, R3=3, PC=4.
REQ-012 SHALL have port Sel_Bus_2_Mux  output  Sel2_size  ALU=0, Bus_1=1, mem_word=2.
REQ-013 SHALL have port write  output  1  memory write strobe, Bus_1 to address.
REQ-014 SHALL have port halted  output  1  high while in S_halt.

Function
REQ-015 SHALL be a 12-state FSM: S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt; state register only, all outputs combinational from state (plus opcode/zero in S_dec).
REQ-016 SHALL decode opcodes NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HALT=15; opcodes 9-14 are illegal.
REQ-017 SHALL, when not named in the current state, drive all enables and write 0 and both selects 0.
REQ-018 S_idle: no outputs; next S_fet1.
REQ-019 S_fet1: Sel1=PC, Sel2=Bus_1, Load_Add_R; next S_fet2.
REQ-020 S_fet2: Sel2=mem, Load_IR, Inc_PC; next S_dec.
REQ-021 S_dec NOP: next S_fet1, no outputs.
REQ-022 S_dec ADD/SUB/AND: Sel1=src, Sel2=Bus_1, Load_Reg_Y; next S_ex1.
REQ-023 S_dec NOT: Sel1=src, Sel2=ALU, Load_Reg_Z, Load_R[dest]; next S_fet1.
REQ-024 S_dec RD/WR/BR: Sel1=PC, Sel2=Bus_1, Load_Add_R; next S_rd1/S_wr1/S_br1 respectively.
REQ-025 S_dec BRZ: zero=1 behaves as BR; zero=0 asserts Inc_PC only (skip operand) and goes to S_fet1.
REQ-026 S_dec HALT or illegal opcode: no outputs; next S_halt.
REQ-027 S_ex1: Sel1=dest, Sel2=ALU, Load_Reg_Z, Load_R[dest]; next S_fet1.
REQ-028 S_rd1: Sel2=mem, Load_Add_R, Inc_PC; next S_rd2.  S_rd2: Sel2=mem, Load_R[dest]; next S_fet1.
REQ-029 S_wr1: Sel2=mem, Load_Add_R, Inc_PC; next S_wr2.  S_wr2: Sel1=src, write; next S_fet1.
REQ-030 S_br1: Sel2=mem, Load_Add_R; next S_br2.  S_br2: Sel2=mem, Load_PC; next S_fet1.
REQ-031 S_halt: halted=1, no other outputs; remains until rst asserted.
REQ-032 Load_Rn SHALL be one-hot-or-zero: at most one of Load_R0..R3 high in any cycle.
REQ-033 Load_PC and Inc_PC SHALL never be high in the same cycle.
REQ-034 Instruction latency: NOP 3, NOT 3, ALU 4, BRZ-not-taken 3, RD/WR/BR/BRZ-taken 5 cycles.

Reset
REQ-035 rst=0 SHALL force state S_idle asynchronously; all outputs 0 while held, including reset mid-instruction.
REQ-036 First S_fet1 SHALL occur one clk after S_idle following rst release.

Structure
REQ-037 Opcode constants, state encoding, Sel_Bus_1/Sel_Bus_2 encodings SHALL live in shared package risc_spm_pkg, also used by the datapath.
REQ-038 Block SHALL be flat: one sequential state process, one combinational next-state/output process; no sub-module.

Verification
REQ-039 Reset then release: idle->fet1; fet1 shows Sel1=4, Sel2=1, Load_Add_R=1; fet2 shows Load_IR=1, Inc_PC=1.
REQ-040 instruction=8'h1B (ADD src=2 dest=3): dec Sel1=2, Load_Reg_Y; ex1 Sel1=3, Sel2=0, Load_R3, Load_Reg_Z; back to fet1.
REQ-041 instruction=8'h80 with zero=0: dec Inc_PC only, next fet1; with zero=1: br1 then br2 Load_PC=1, Sel2=2.
REQ-042 instruction=8'h64 (WR src=1): wr1 Inc_PC+Load_Add_R; wr2 Sel1=1, write=1 one cycle only.
REQ-043 instruction=8'hF0 and 8'h90: enter S_halt, halted=1 for 20 clocks; rst pulse mid-halt returns to idle.
REQ-044 Bench SHALL assert REQ-032/033 every cycle and rst asserted in S_rd1 yields S_idle with all outputs 0 before next edge.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared RISC-SPM encodings: opcodes, control FSM states and bus mux selects.
// Used by both the control unit and the datapath.
package risc_spm_pkg;

  typedef enum logic [3:0] {
    S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2,
    S_wr1, S_wr2, S_br1, S_br2, S_halt
  } state_t;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpNot  = 4'd4;
  localparam logic [3:0] OpRd   = 4'd5;
  localparam logic [3:0] OpWr   = 4'd6;
  localparam logic [3:0] OpBr   = 4'd7;
  localparam logic [3:0] OpBrz  = 4'd8;
  localparam logic [3:0] OpHalt = 4'd15;

  localparam logic [2:0] Sel1R0 = 3'd0;
  localparam logic [2:0] Sel1R1 = 3'd1;
  localparam logic [2:0] Sel1R2 = 3'd2;
  localparam logic [2:0] Sel1R3 = 3'd3;
  localparam logic [2:0] Sel1Pc = 3'd4;

  localparam logic [1:0] Sel2Alu  = 2'd0;
  localparam logic [1:0] Sel2Bus1 = 2'd1;
  localparam logic [1:0] Sel2Mem  = 2'd2;

endpackage

// File: rtl/control_unit.sv
// RISC-SPM control FSM: state register plus combinational decode of state,
// opcode and zero flag into datapath enables and bus selects.
module control_unit
  import risc_spm_pkg::*;
#(
  parameter int word_size = 8,
  parameter int op_size   = 4,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 write,
  output logic                 halted
);

  state_t state_q, state_d;

  logic [op_size-1:0] opcode;
  logic [1:0]         src, dest;
  logic [3:0]         load_r, dest_onehot;
  logic [2:0]         sel1;
  logic [1:0]         sel2;

  assign opcode      = instruction[word_size-1 -: op_size];
  assign src         = instruction[3:2];
  assign dest        = instruction[1:0];
  assign dest_onehot = 4'b0001 << dest;

  assign Load_R0       = load_r[0];
  assign Load_R1       = load_r[1];
  assign Load_R2       = load_r[2];
  assign Load_R3       = load_r[3];
  assign Sel_Bus_1_Mux = Sel1_size'(sel1);
  assign Sel_Bus_2_Mux = Sel2_size'(sel2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_idle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_r     = 4'b0000;
    Load_IR    = 1'b0;
    Load_Add_R = 1'b0;
    Load_Reg_Y = 1'b0;
    Load_Reg_Z = 1'b0;
    Load_PC    = 1'b0;
    Inc_PC     = 1'b0;
    sel1       = Sel1R0;
    sel2       = Sel2Alu;
    write      = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_idle: state_d = S_fet1;
      S_fet1: begin
        sel1       = Sel1Pc;
        sel2       = Sel2Bus1;
        Load_Add_R = 1'b1;
        state_d    = S_fet2;
      end
      S_fet2: begin
        sel2    = Sel2Mem;
        Load_IR = 1'b1;
        Inc_PC  = 1'b1;
        state_d = S_dec;
      end
      S_dec: begin
        case (opcode)
          OpNop: state_d = S_fet1;
          OpAdd, OpSub, OpAnd: begin
            sel1       = {1'b0, src};
            sel2       = Sel2Bus1;
            Load_Reg_Y = 1'b1;
            state_d    = S_ex1;
          end
          OpNot: begin
            sel1       = {1'b0, src};
            sel2       = Sel2Alu;
            Load_Reg_Z = 1'b1;
            load_r     = dest_onehot;
            state_d    = S_fet1;
          end
          OpRd, OpWr, OpBr, OpBrz: begin
            if (opcode == OpBrz && !zero) begin
              // Branch not taken: step PC over the target-address word.
              Inc_PC  = 1'b1;
              state_d = S_fet1;
            end else begin
              sel1       = Sel1Pc;
              sel2       = Sel2Bus1;
              Load_Add_R = 1'b1;
              if (opcode == OpRd)      state_d = S_rd1;
              else if (opcode == OpWr) state_d = S_wr1;
              else                     state_d = S_br1;
            end
          end
          default: state_d = S_halt;
        endcase
      end
      S_ex1: begin
        sel1       = {1'b0, dest};
        sel2       = Sel2Alu;
        Load_Reg_Z = 1'b1;
        load_r     = dest_onehot;
        state_d    = S_fet1;
      end
      S_rd1: begin
        sel2       = Sel2Mem;
        Load_Add_R = 1'b1;
        Inc_PC     = 1'b1;
        state_d    = S_rd2;
      end
      S_rd2: begin
        sel2    = Sel2Mem;
        load_r  = dest_onehot;
        state_d = S_fet1;
      end
      S_wr1: begin
        sel2       = Sel2Mem;
        Load_Add_R = 1'b1;
        Inc_PC     = 1'b1;
        state_d    = S_wr2;
      end
      S_wr2: begin
        sel1    = {1'b0, src};
        write   = 1'b1;
        state_d = S_fet1;
      end
      S_br1: begin
        sel2       = Sel2Mem;
        Load_Add_R = 1'b1;
        state_d    = S_br2;
      end
      S_br2: begin
        sel2    = Sel2Mem;
        Load_PC = 1'b1;
        state_d = S_fet1;
      end
      S_halt: halted = 1'b1;
      default: state_d = S_idle;
    endcase
  end

endmodule
